// File: rtl/mcb_dat_pkg.sv
// mcb_dat_pkg: shared state encodings, burst-length decode and CAS-latency default for the data-phase sequencer.
package mcb_dat_pkg;
    localparam int MAX_CL_DEF = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LAT  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        TA   = 3'd4
    } dat_st_e;

    function automatic logic [3:0] bl_beats(input logic [1:0] code);
        return 4'd1 << code;
    endfunction
endpackage

// File: rtl/mcb_dat_lat_cnt.sv
// mcb_dat_lat_cnt: loadable saturating latency down-counter with an expired flag.
module mcb_dat_lat_cnt #(
    parameter int W = 2
) (
    input  logic         mcb_clk,
    input  logic         mcb_rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt,
    output logic         expired
);
    assign expired = cnt == '0;

    always_ff @(posedge mcb_clk or posedge mcb_rst)
        if (mcb_rst) cnt <= '0;
        else cnt <= clr ? '0 : ld ? ld_val : expired ? cnt : cnt - 1'b1;
endmodule

// File: rtl/mcb_dat_seq.sv
// mcb_dat_seq: SDR data-phase sequencer with runtime CL/BL and a one-deep pending slot.
// Define MCB_DAT_TURNAROUND_EN to insert one bubble cycle on read/write direction changes.
module mcb_dat_seq
    import mcb_dat_pkg::*;
#(
    parameter int MAX_CL    = MAX_CL_DEF,
    parameter int CL_W      = 2,
    parameter int BST_NUM_W = 2,
    parameter int BEAT_W    = BST_NUM_W + 3
) (
    input  logic                 mcb_clk,
    input  logic                 mcb_rst,
    input  logic                 mcb_sclr_n,
    input  logic [CL_W-1:0]      cfg_cl,
    input  logic [1:0]           cfg_bl,
    input  logic                 cmd_rd,
    input  logic                 cmd_wr,
    input  logic [BST_NUM_W-1:0] cmd_bst_num,
    output logic                 cmd_rdy,
    output logic                 d_dp_ie,
    output logic                 d_dp_oe,
    output logic [BEAT_W-1:0]    d_beat_cnt,
    output logic                 d_last,
    output logic                 d_busy,
    output logic                 d_err
);
    localparam int LW = $clog2(MAX_CL + 1);
`ifdef MCB_DAT_TURNAROUND_EN
    localparam bit TA_EN = 1'b1;
`else
    localparam bit TA_EN = 1'b0;
`endif

    dat_st_e           st, st_n;
    logic [BEAT_W-1:0] beat_cnt, beat_n, bm1, bm1_n, pend_bm1, pbm1_n, nb;
    logic              pend_vld, pv_n, pend_rd, prd_n, err, err_n;
    logic [LW-1:0]     cl_eff, acnt, pcnt, a_val;
    logic              a_ld, p_ld, a_exp, p_exp;
    logic              acc, fin, cur_rd, dc_pend, dc_new, start_new, to_slot, promote, go_ta;
    int                cl_i;

    always_comb begin
        cl_i = int'(cfg_cl);
        cl_i = cl_i == 0 ? 1 : cl_i > MAX_CL ? MAX_CL : cl_i;
    end
    assign cl_eff = LW'(cl_i);

    // beats-1 = bst*bl + (bl-1); bl is a power of two so the product is a shift
    assign nb = (BEAT_W'(cmd_bst_num) << cfg_bl) + BEAT_W'(bl_beats(cfg_bl) - 4'd1);

    assign acc       = (cmd_rd ^ cmd_wr) & ~pend_vld;
    assign cur_rd    = st == RD;
    assign fin       = (st == RD || st == WR) && beat_cnt == bm1;
    assign dc_pend   = TA_EN && (pend_rd != cur_rd);
    assign dc_new    = TA_EN && (cmd_rd != cur_rd);
    assign start_new = acc && (st == IDLE || (fin && !dc_new));
    assign to_slot   = acc && !start_new;
    assign promote   = st == TA || (fin && pend_vld && !dc_pend);
    assign go_ta     = fin && (pend_vld ? dc_pend : acc && dc_new);
    assign p_ld      = to_slot && cmd_rd && mcb_sclr_n;

    mcb_dat_lat_cnt #(.W(LW)) u_act_lat (
        .mcb_clk (mcb_clk),
        .mcb_rst (mcb_rst),
        .clr     (!mcb_sclr_n),
        .ld      (a_ld),
        .ld_val  (a_val),
        .cnt     (acnt),
        .expired (a_exp)
    );

    mcb_dat_lat_cnt #(.W(LW)) u_pend_lat (
        .mcb_clk (mcb_clk),
        .mcb_rst (mcb_rst),
        .clr     (!mcb_sclr_n),
        .ld      (p_ld),
        .ld_val  (cl_eff),
        .cnt     (pcnt),
        .expired (p_exp)
    );

    always_comb begin
        st_n   = st;
        beat_n = '0;
        bm1_n  = bm1;
        pv_n   = pend_vld;
        prd_n  = pend_rd;
        pbm1_n = pend_bm1;
        err_n  = cmd_rd & cmd_wr;
        a_ld   = 1'b0;
        a_val  = cl_eff;
        if (st == LAT && (acnt == LW'(1) || a_exp)) st_n = RD;
        if ((st == RD || st == WR) && !fin) beat_n = beat_cnt + 1'b1;
        if (fin) st_n = IDLE;
        if (go_ta) st_n = TA;
        if (to_slot) begin
            pv_n   = 1'b1;
            prd_n  = cmd_rd;
            pbm1_n = nb;
        end
        if (start_new) begin
            st_n  = cmd_rd ? LAT : WR;
            bm1_n = nb;
            a_ld  = cmd_rd;
        end
        // a pending read whose latency already ran out still gets the bus, but flags the miss
        if (promote) begin
            pv_n  = 1'b0;
            bm1_n = pend_bm1;
            if (!pend_rd) st_n = WR;
            else if (pcnt > LW'(1)) begin
                st_n  = LAT;
                a_ld  = 1'b1;
                a_val = pcnt - 1'b1;
            end else begin
                st_n  = RD;
                err_n = err_n | p_exp;
            end
        end
        if (!mcb_sclr_n) begin
            st_n   = IDLE;
            beat_n = '0;
            bm1_n  = '0;
            pv_n   = 1'b0;
            prd_n  = 1'b0;
            pbm1_n = '0;
            err_n  = 1'b0;
            a_ld   = 1'b0;
        end
    end

    always_ff @(posedge mcb_clk or posedge mcb_rst)
        if (mcb_rst) begin
            st       <= IDLE;
            beat_cnt <= '0;
            bm1      <= '0;
            pend_vld <= 1'b0;
            pend_rd  <= 1'b0;
            pend_bm1 <= '0;
            err      <= 1'b0;
        end else begin
            st       <= st_n;
            beat_cnt <= beat_n;
            bm1      <= bm1_n;
            pend_vld <= pv_n;
            pend_rd  <= prd_n;
            pend_bm1 <= pbm1_n;
            err      <= err_n;
        end

    assign cmd_rdy    = !pend_vld;
    assign d_dp_ie    = st == RD;
    assign d_dp_oe    = st == WR;
    assign d_beat_cnt = beat_cnt;
    assign d_last     = fin;
    assign d_busy     = st != IDLE || pend_vld;
    assign d_err      = err;
endmodule
